// File: rtl/seg_display_scheduler.sv
// Signed 8-bit result -> three BCD digits (shift-add-3) -> time-multiplexed digit/sign drive for a 4-digit 7-seg decoder.
// Latency: load accepted in IDLE, 8 SHIFT cycles, 1 COMMIT; done pulses 10 cycles after load; display outputs registered (+1 clk).
// Backpressure: none; load while busy is dropped. Optional leading-zero blanking under `SEG_LZ_BLANK_EN.
module seg_display_scheduler #(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic       en,
    output logic [1:0] count,
    output logic [3:0] num,
    output logic       sign
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  mag, mag_nxt;
    logic [11:0] bcd, bcd_nxt, bcd_adj;
    logic [3:0]  iter, iter_nxt;
    logic        neg_p, neg_p_nxt;
    logic        busy_nxt, done_nxt;
    logic [3:0]  dig0, dig1, dig2;
    logic [3:0]  dig0_nxt, dig1_nxt, dig2_nxt;
    logic        neg_c, neg_c_nxt;

    logic [REFRESH_BITS-1:0] pre;
    logic [1:0]              slot_nxt;
    logic [3:0]              num_nxt;
    logic                    en_nxt;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Conversion FSM: next state and datapath
    always_comb begin
        state_nxt = state;
        mag_nxt   = mag;
        bcd_nxt   = bcd;
        iter_nxt  = iter;
        neg_p_nxt = neg_p;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        dig0_nxt  = dig0;
        dig1_nxt  = dig1;
        dig2_nxt  = dig2;
        neg_c_nxt = neg_c;
        bcd_adj   = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
        case (state)
            IDLE: begin
                if (load) begin
                    // Two's-complement negate; 8'h80 maps to 128 as an unsigned magnitude.
                    mag_nxt   = value[7] ? (~value + 8'd1) : value;
                    neg_p_nxt = value[7];
                    bcd_nxt   = 12'd0;
                    iter_nxt  = 4'd8;
                    busy_nxt  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bcd_nxt  = {bcd_adj[10:0], mag[7]};
                mag_nxt  = {mag[6:0], 1'b0};
                iter_nxt = iter - 4'd1;
                if (iter == 4'd1) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                dig0_nxt  = bcd[3:0];
                dig1_nxt  = bcd[7:4];
                dig2_nxt  = bcd[11:8];
                neg_c_nxt = neg_p;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mag   <= 8'd0;
            bcd   <= 12'd0;
            iter  <= 4'd0;
            neg_p <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dig0  <= 4'd0;
            dig1  <= 4'd0;
            dig2  <= 4'd0;
            neg_c <= 1'b0;
        end else begin
            state <= state_nxt;
            mag   <= mag_nxt;
            bcd   <= bcd_nxt;
            iter  <= iter_nxt;
            neg_p <= neg_p_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            dig0  <= dig0_nxt;
            dig1  <= dig1_nxt;
            dig2  <= dig2_nxt;
            neg_c <= neg_c_nxt;
        end
    end

    // Refresh scheduler: slot advances when the prescaler wraps; mux uses the digits committed so far.
    always_comb begin
        slot_nxt = (&pre) ? count + 2'd1 : count;
        case (slot_nxt)
            2'd0:    num_nxt = dig0;
            2'd1:    num_nxt = dig1;
            2'd2:    num_nxt = dig2;
            default: num_nxt = 4'd0;
        endcase
        en_nxt = 1'b1;
`ifdef SEG_LZ_BLANK_EN
        if (slot_nxt == 2'd2 && dig2 == 4'd0) begin
            en_nxt = 1'b0;
        end
        if (slot_nxt == 2'd1 && dig2 == 4'd0 && dig1 == 4'd0) begin
            en_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre   <= '0;
            count <= 2'd0;
            num   <= 4'd0;
            en    <= 1'b1;
            sign  <= 1'b1;
        end else begin
            pre   <= pre + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            count <= slot_nxt;
            num   <= num_nxt;
            en    <= en_nxt;
            sign  <= ~neg_c;
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: arithmetic reference model checked every cycle, plus literal digit/latency pins.
module tb_seg_display_scheduler;
    localparam int RB = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] value = 8'd0;
    logic       load = 1'b0;
    logic       busy, done, en, sign;
    logic [1:0] count;
    logic [3:0] num;

    seg_display_scheduler #(.REFRESH_BITS(RB)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .busy(busy), .done(done), .en(en), .count(count), .num(num), .sign(sign)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: edge index since reset, last accepted load edge, committed and displayed digits.
    int m_n, m_tacc, mag;
    int m_dig[3], p_dig[3], s_dig[3];
    bit m_neg, p_neg, s_neg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_tacc = -100;
            m_dig = '{0, 0, 0}; s_dig = '{0, 0, 0}; p_dig = '{0, 0, 0};
            m_neg = 0; s_neg = 0; p_neg = 0;
        end else begin
            m_n++;
            if (load && m_n >= m_tacc + 10) begin
                mag = value[7] ? 256 - int'(value) : int'(value);
                p_dig[0] = mag % 10;
                p_dig[1] = (mag / 10) % 10;
                p_dig[2] = mag / 100;
                p_neg = value[7];
                m_tacc = m_n;
            end
            s_dig = m_dig;
            s_neg = m_neg;
            if (m_n == m_tacc + 9) begin
                m_dig = p_dig;
                m_neg = p_neg;
            end
        end
    end

    bit pin_vld = 0;
    int pin_dig[3];
    int pin_en[4];
    int pin_sign;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int c, e_num, e_en;
        c = (m_n >> RB) % 4;
        e_num = (c == 3) ? 0 : s_dig[c];
        e_en = 1;
`ifdef SEG_LZ_BLANK_EN
        if (c == 2 && s_dig[2] == 0) e_en = 0;
        if (c == 1 && s_dig[2] == 0 && s_dig[1] == 0) e_en = 0;
`endif
        chk("busy", int'(busy), (m_n >= m_tacc && m_n <= m_tacc + 8) ? 1 : 0);
        chk("done", int'(done), (m_n == m_tacc + 9) ? 1 : 0);
        chk("count", int'(count), c);
        chk("num", int'(num), e_num);
        chk("sign", int'(sign), s_neg ? 0 : 1);
        chk("en", int'(en), e_en);
        if (pin_vld) begin
            if (count != 2'd3) chk("pin_num", int'(num), pin_dig[count]);
            chk("pin_sign", int'(sign), pin_sign);
            chk("pin_en", int'(en), pin_en[count]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_load(input logic [7:0] v);
        value = v;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 30) begin
            cyc();
            k++;
        end
        chk("idle_timeout", int'(busy), 0);
        repeat (2) cyc();
    endtask

    task automatic show(input int d0, input int d1, input int d2, input int sg, input int e1, input int e2);
        pin_dig = '{d0, d1, d2};
        pin_en = '{1, e1, e2, 1};
        pin_sign = sg;
        pin_vld = 1;
        repeat (16) cyc();
        pin_vld = 0;
    endtask

    int lat, bcnt, lz;

    initial begin
`ifdef SEG_LZ_BLANK_EN
        lz = 0;
`else
        lz = 1;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("cnt_lit3", int'(count), 0);
        cyc();
        chk("cnt_lit4", int'(count), 1);
        show(0, 0, 0, 1, lz, lz);

        // 127: latency and busy width
        value = 8'd127;
        load = 1'b1;
        lat = 0; bcnt = 0;
        while (!done && lat < 20) begin
            cyc();
            load = 1'b0;
            lat++;
            if (busy) bcnt++;
        end
        chk("done_latency", lat, 10);
        chk("busy_cycles", bcnt, 9);
        wait_idle();
        show(7, 2, 1, 1, 1, 1);

        do_load(8'h80);
        wait_idle();
        show(8, 2, 1, 0, 1, 1);

        // -5 then 99 while busy: second load dropped
        do_load(8'hFB);
        repeat (2) cyc();
        do_load(8'd99);
        wait_idle();
        show(5, 0, 0, 0, lz, lz);

        // 42 aborted by reset in the 4th SHIFT cycle
        do_load(8'd42);
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        check_all();
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (15) cyc();
        show(0, 0, 0, 1, lz, lz);

        do_load(8'd0);
        wait_idle();
        show(0, 0, 0, 1, lz, lz);

        // load held high: back-to-back conversions every 10 cycles
        value = 8'hC8;
        load = 1'b1;
        repeat (40) cyc();
        load = 1'b0;
        wait_idle();

        repeat (400) begin
            value = 8'($urandom);
            load = ($urandom_range(0, 3) == 0);
            cyc();
        end
        load = 1'b0;
        wait_idle();
        repeat (16) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
